valve_driver: RTL
=================

VALVE_DRIVER -- requirements
Module: valve_driver

Interface
REQ-001 Parameter DEB, default 3, consecutive sampled-high cycles of C[i] needed to open valve i; legal range 2..255.
REQ-002 Parameter MIN_ON, default 8, minimum cycles valve i stays open once opened; legal range 1..255.
REQ-003 Parameter MIN_OFF, default 8, cycles valve i is held closed after a normal close; legal range 1..255.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  system clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous active-low reset.
REQ-007 C  input  2  per-channel water request from the level controller (1 = Agua, 0 = No_Agua).
REQ-008 Pout  input  2  per-channel error flag from the level controller (1 = Error).
REQ-009 ack  input  2  per-channel alarm acknowledge from operator.
REQ-010 valve  output  2  registered valve drive, 1 = open.
REQ-011 alarm  output  2  registered latched fault indication.
REQ-012 busy  output  2  registered, 1 while channel is in WAIT_ON or HOLD_OFF.
REQ-013 fault_cnt  output  8  bits [3:0] channel 0, bits [7:4] channel 1; saturating fault-entry counts.

Function
REQ-014 Channels 0 and 1 SHALL be identical, independent FSMs; no input of one affects the other.
REQ-015 Per-channel states SHALL be IDLE, WAIT_ON, ON, HOLD_OFF, FAULT; valve[i]=1 only in ON, alarm[i]=1 only in FAULT.
REQ-016 Pout[i]=1 sampled at any edge SHALL move channel i to FAULT at that edge, overriding every other transition; in FAULT with Pout[i]=1 it stays in FAULT.
REQ-017 Each entry into FAULT from a non-FAULT state SHALL increment that channel's fault_cnt nibble, saturating at 15.
REQ-018 IDLE: C[i]=1 -> WAIT_ON with debounce count 1; else stay.
REQ-019 WAIT_ON: C[i]=0 -> IDLE (count discarded); C[i]=1 with count = DEB-1 -> ON; else count+1.
REQ-020 Net effect: valve[i] rises after the DEB-th consecutive rising edge sampling C[i]=1.
REQ-021 ON entry SHALL set on-count to 1; on-count increments each cycle in ON, saturating at 255.
REQ-022 ON: C[i]=0 with on-count >= MIN_ON -> HOLD_OFF; C[i]=0 earlier is ignored (no latching of early release); C[i]=1 stays ON.
REQ-023 HOLD_OFF entry SHALL set off-count to 1; off-count = MIN_OFF -> IDLE, else off-count+1; C[i] ignored throughout.
REQ-024 FAULT: ack[i]=1 and Pout[i]=0 sampled at the same edge -> HOLD_OFF (off-count 1); ack[i] while Pout[i]=1 is ignored; ack[i] in other states has no effect.
REQ-025 After HOLD_OFF, reopening SHALL require a full new DEB debounce from IDLE.
REQ-026 All outputs SHALL be registered; state change and output change occur at the same edge, no combinational input-to-output path.

Reset
REQ-027 reset=0 at a rising edge SHALL force both channels to IDLE, clear all internal counters, and drive valve=00, alarm=00, busy=00, fault_cnt=0x00, overriding Pout, C and ack.
REQ-028 Reset asserted mid-operation (ON, HOLD_OFF, FAULT) SHALL take effect at the next rising edge with no residual min-on/min-off enforcement after release.
REQ-029 fault_cnt SHALL be cleared only by reset.

Verification
REQ-030 Defaults, reset released, C=01 held -> valve=01 after 3rd edge sampling C[0]=1; busy[0]=1 for the 2 preceding cycles; valve[1]=0.
REQ-031 C[0] high for 2 edges then low -> valve stays 00, channel returns to IDLE, busy[0] drops.
REQ-032 Valve[0] open, C[0] dropped after 2 cycles -> valve[0] held 1 for 8 cycles total, then 0 for exactly 8 cycles in HOLD_OFF despite C[0]=1, then reopens 3 edges later.
REQ-033 Valve[1] open, Pout=10 for 1 edge -> valve[1]=0, alarm[1]=1, fault_cnt=0x10 next cycle; ack=10 with Pout=10 -> no change; ack=10 with Pout=00 -> alarm[1]=0, busy[1]=1 for 8 cycles.
REQ-034 16 Pout[0] pulses each separated by ack -> fault_cnt[3:0] saturates at 15.
REQ-035 reset=0 for 1 edge with both channels ON and fault_cnt nonzero -> all outputs zero next cycle; C=11 after release reopens both valves after 3 edges.

Source files
------------

// File: rtl/valve_driver.sv
// Two independent valve channels: debounced open, minimum on/off times,
// latched fault with operator acknowledge and saturating fault counters.
module valve_driver #(
  parameter int DEB     = 3,
  parameter int MIN_ON  = 8,
  parameter int MIN_OFF = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] C,
  input  logic [1:0] Pout,
  input  logic [1:0] ack,
  output logic [1:0] valve,
  output logic [1:0] alarm,
  output logic [1:0] busy,
  output logic [7:0] fault_cnt
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ON  = 3'd1,
    ON       = 3'd2,
    HOLD_OFF = 3'd3,
    FAULT    = 3'd4
  } state_t;

  localparam logic [7:0] DEB_LAST = 8'(DEB - 1);
  localparam logic [7:0] ON_MIN   = 8'(MIN_ON);
  localparam logic [7:0] OFF_LAST = 8'(MIN_OFF);

  state_t     r_state    [2];
  state_t     w_state_nxt[2];
  logic [7:0] r_cnt      [2];
  logic [7:0] w_cnt_nxt  [2];
  logic [3:0] r_fcnt     [2];
  logic [3:0] w_fcnt_nxt [2];
  logic [1:0] r_valve;
  logic [1:0] r_alarm;
  logic [1:0] r_busy;

  // Per-channel next state; one shared counter serves debounce, on and off timing.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      w_fcnt_nxt[i]  = r_fcnt[i];
      if (Pout[i]) begin
        w_state_nxt[i] = FAULT;
        w_cnt_nxt[i]   = 8'd0;
        if (r_state[i] != FAULT && r_fcnt[i] != 4'd15) begin
          w_fcnt_nxt[i] = r_fcnt[i] + 4'd1;
        end else begin
          w_fcnt_nxt[i] = r_fcnt[i];
        end
      end else begin
        case (r_state[i])
          IDLE: begin
            if (C[i]) begin
              w_state_nxt[i] = WAIT_ON;
              w_cnt_nxt[i]   = 8'd1;
            end else begin
              w_cnt_nxt[i]   = 8'd0;
            end
          end
          WAIT_ON: begin
            if (!C[i]) begin
              w_state_nxt[i] = IDLE;
              w_cnt_nxt[i]   = 8'd0;
            end else if (r_cnt[i] == DEB_LAST) begin
              w_state_nxt[i] = ON;
              w_cnt_nxt[i]   = 8'd1;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i] + 8'd1;
            end
          end
          ON: begin
            if (!C[i] && r_cnt[i] >= ON_MIN) begin
              w_state_nxt[i] = HOLD_OFF;
              w_cnt_nxt[i]   = 8'd1;
            end else if (r_cnt[i] != 8'hFF) begin
              w_cnt_nxt[i]   = r_cnt[i] + 8'd1;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i];
            end
          end
          HOLD_OFF: begin
            if (r_cnt[i] == OFF_LAST) begin
              w_state_nxt[i] = IDLE;
              w_cnt_nxt[i]   = 8'd0;
            end else begin
              w_cnt_nxt[i]   = r_cnt[i] + 8'd1;
            end
          end
          FAULT: begin
            if (ack[i]) begin
              w_state_nxt[i] = HOLD_OFF;
              w_cnt_nxt[i]   = 8'd1;
            end else begin
              w_cnt_nxt[i]   = 8'd0;
            end
          end
          default: begin
            w_state_nxt[i] = IDLE;
            w_cnt_nxt[i]   = 8'd0;
          end
        endcase
      end
    end
  end

  // State, counters and outputs update together so outputs track state exactly.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= 8'd0;
        r_fcnt[i]  <= 4'd0;
      end
      r_valve <= 2'b00;
      r_alarm <= 2'b00;
      r_busy  <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
        r_fcnt[i]  <= w_fcnt_nxt[i];
        r_valve[i] <= (w_state_nxt[i] == ON);
        r_alarm[i] <= (w_state_nxt[i] == FAULT);
        r_busy[i]  <= (w_state_nxt[i] == WAIT_ON) || (w_state_nxt[i] == HOLD_OFF);
      end
    end
  end

  assign valve     = r_valve;
  assign alarm     = r_alarm;
  assign busy      = r_busy;
  assign fault_cnt = {r_fcnt[1], r_fcnt[0]};

endmodule
